// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, sequencer states, flag bit positions.
// Used by the ALU, its control decoder and the operation sequencer.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_SUB  = 4'b0011,
      OP_SLT  = 4'b0100,
      OP_SLL  = 4'b0101,
      OP_SRL  = 4'b0110,
      OP_XOR  = 4'b0111,
      OP_NOR  = 4'b1000,
      OP_NAND = 4'b1001
   } alu_op_e;

   localparam logic [3:0] OP_LAST_LEGAL = OP_NAND;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_HOLD  = 2'd2
   } seq_state_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic op_is_legal(input logic [3:0] op);
      return (op <= OP_LAST_LEGAL);
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for queued ALU commands.
// Pointers wrap modulo DEPTH; occupancy kept in a registered count.
module cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNTW-1:0]  count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNTW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents need no reset since the count guards reads.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, drives the ALU operands, waits for the result
// to settle and returns it with its flags over a valid/ready response port.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int W      = 32,
   parameter int DEPTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [3:0]   cmd_op,
   input  logic [W-1:0] cmd_a,
   input  logic [W-1:0] cmd_b,
   output logic [W-1:0] alu_i1,
   output logic [W-1:0] alu_i2,
   output logic [3:0]   alu_ctr,
   input  logic [W-1:0] alu_out,
   input  logic         alu_n,
   input  logic         alu_z,
   input  logic         alu_c,
   input  logic         alu_v,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic [3:0]   rsp_flags,
   output logic         rsp_illegal
);

   localparam int FW = 4 + 2 * W;
   localparam int CW = $clog2(SETTLE + 1);

   seq_state_e    state;
   seq_state_e    state_nx;
   logic [CW-1:0] settle_cnt;
   logic          ready_en;

   logic          f_push;
   logic          f_pop;
   logic [FW-1:0] f_wdata;
   logic [FW-1:0] f_rdata;
   logic          f_full;
   logic          f_empty;

   logic [3:0]    h_op;
   logic [W-1:0]  h_a;
   logic [W-1:0]  h_b;
   logic [3:0]    flags_in;

   logic          load_alu;
   logic          load_ill;
   logic          capture;
   logic          rsp_clr;
   logic          cnt_inc;

   assign cmd_ready = ready_en && !f_full;
   assign f_push    = cmd_valid && cmd_ready;
   assign f_wdata   = {cmd_op, cmd_a, cmd_b};

   assign h_op = f_rdata[FW-1 -: 4];
   assign h_a  = f_rdata[2*W-1 -: W];
   assign h_b  = f_rdata[W-1:0];

   cmd_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (f_push),
      .wdata (f_wdata),
      .pop   (f_pop),
      .rdata (f_rdata),
      .full  (f_full),
      .empty (f_empty)
   );

   // Place the ALU flags at their agreed bit positions.
   always_comb begin
      flags_in         = '0;
      flags_in[FLAG_N] = alu_n;
      flags_in[FLAG_Z] = alu_z;
      flags_in[FLAG_C] = alu_c;
      flags_in[FLAG_V] = alu_v;
   end

   // Command acceptance opens one edge after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next state and datapath strobes; dispatch of the FIFO head happens
   // from IDLE or straight out of HOLD once the response is taken.
   always_comb begin
      logic dispatch;
      state_nx = state;
      f_pop    = 1'b0;
      load_alu = 1'b0;
      load_ill = 1'b0;
      capture  = 1'b0;
      rsp_clr  = 1'b0;
      cnt_inc  = 1'b0;
      dispatch = 1'b0;
      unique case (state)
         ST_IDLE: begin
            dispatch = 1'b1;
         end
         ST_DRIVE: begin
            cnt_inc = 1'b1;
            if (settle_cnt == CW'(SETTLE - 1)) begin
               capture  = 1'b1;
               state_nx = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (rsp_valid && rsp_ready) begin
               rsp_clr  = 1'b1;
               dispatch = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
      if (dispatch && !f_empty) begin
         f_pop = 1'b1;
         if (op_is_legal(h_op)) begin
            load_alu = 1'b1;
            state_nx = ST_DRIVE;
         end else begin
            load_ill = 1'b1;
            state_nx = ST_HOLD;
         end
      end
   end

   // ALU operand drive; only legal commands update it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_i1  <= '0;
         alu_i2  <= '0;
         alu_ctr <= '0;
      end else if (load_alu) begin
         alu_i1  <= h_a;
         alu_i2  <= h_b;
         alu_ctr <= h_op;
      end
   end

   // Settle counter: restarts on each operand load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       settle_cnt <= '0;
      else if (load_alu) settle_cnt <= '0;
      else if (cnt_inc)  settle_cnt <= settle_cnt + 1'b1;
   end

   // Response register: captured result, illegal marker, or handshake drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_flags   <= '0;
         rsp_illegal <= 1'b0;
      end else if (capture) begin
         rsp_valid   <= 1'b1;
         rsp_data    <= alu_out;
         rsp_flags   <= flags_in;
         rsp_illegal <= 1'b0;
      end else if (load_ill) begin
         rsp_valid   <= 1'b1;
         rsp_data    <= '0;
         rsp_flags   <= '0;
         rsp_illegal <= 1'b1;
      end else if (rsp_clr) begin
         rsp_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU
// and a queue-based model of the expected responses.
module tb_alu_op_sequencer;

   localparam int W      = 32;
   localparam int DEPTH  = 4;
   localparam int SETTLE = 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [3:0]   cmd_op = '0;
   logic [W-1:0] cmd_a = '0;
   logic [W-1:0] cmd_b = '0;
   logic [W-1:0] alu_i1;
   logic [W-1:0] alu_i2;
   logic [3:0]   alu_ctr;
   logic [W-1:0] alu_out;
   logic         alu_n;
   logic         alu_z;
   logic         alu_c;
   logic         alu_v;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_data;
   logic [3:0]   rsp_flags;
   logic         rsp_illegal;

   int n_chk = 0;
   int n_err = 0;
   int n_rsp = 0;
   int n_acc = 0;
   logic last_cf = 1'b0;
   logic [36:0] exp_q[$];

   always #5 clk = ~clk;

   alu_op_sequencer #(
      .W      (W),
      .DEPTH  (DEPTH),
      .SETTLE (SETTLE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .alu_i1      (alu_i1),
      .alu_i2      (alu_i2),
      .alu_ctr     (alu_ctr),
      .alu_out     (alu_out),
      .alu_n       (alu_n),
      .alu_z       (alu_z),
      .alu_c       (alu_c),
      .alu_v       (alu_v),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_flags   (rsp_flags),
      .rsp_illegal (rsp_illegal)
   );

   // Behavioural ALU: returns {N,Z,C,V,result}.
   function automatic logic [35:0] alu_ref(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic        c;
      logic        v;
      c = 1'b0;
      v = 1'b0;
      s = '0;
      case (op)
         4'd0: r = a & b;
         4'd1: r = a | b;
         4'd2: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0];
            c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'd3: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = s[31:0];
            c = s[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd5: r = a << b[4:0];
         4'd6: r = a >> b[4:0];
         4'd7: r = a ^ b;
         4'd8: r = ~(a | b);
         4'd9: r = ~(a & b);
         default: r = '0;
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   // Expected response {illegal, flags, data} for one command.
   function automatic logic [36:0] model(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      if (op > 4'd9) return {1'b1, 36'd0};
      return {1'b0, alu_ref(op, a, b)};
   endfunction

   always_comb begin
      {alu_n, alu_z, alu_c, alu_v, alu_out} = alu_ref(alu_ctr, alu_i1, alu_i2);
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: score handshakes seen before the edge, then check stall stability.
   task automatic step();
      logic        cf;
      logic        rf;
      logic        stl;
      logic [36:0] pay;
      cf  = cmd_valid && cmd_ready;
      rf  = rsp_valid && rsp_ready;
      stl = rsp_valid && !rsp_ready;
      pay = {rsp_illegal, rsp_flags, rsp_data};
      if (rf) begin
         n_rsp++;
         chk("rsp_pending", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) chk("rsp_payload", 64'(pay), 64'(exp_q.pop_front()));
      end
      if (cf) begin
         n_acc++;
         exp_q.push_back(model(cmd_op, cmd_a, cmd_b));
      end
      last_cf = cf;
      @(posedge clk);
      #1;
      if (stl)
         chk("rsp_stable", {27'd0, rsp_valid, rsp_illegal, rsp_flags, rsp_data},
             {27'd0, 1'b1, pay});
   endtask

   task automatic send(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
      int k;
      k = 0;
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_a = a;
      cmd_b = b;
      do begin
         step();
         k++;
      end while (!last_cf && k < 20);
      cmd_valid = 1'b0;
      chk("cmd_accept", 64'(last_cf), 64'd1);
   endtask

   task automatic wait_rsp();
      int k;
      k = 0;
      while (!rsp_valid && k < 20) begin
         step();
         k++;
      end
      chk("rsp_timeout", 64'(rsp_valid), 64'd1);
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] a_and;
      logic        acc6;
      int          k;
      int          r0;

      // Reset state
      #12;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst_rsp", {27'd0, rsp_valid, rsp_illegal, rsp_flags, rsp_data}, 64'd0);
      chk("rst_alu", {alu_ctr, alu_i1}, 64'd0);
      chk("rst_alu_i2", 64'(alu_i2), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_cmd_ready_low", 64'(cmd_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("rel_cmd_ready_high", 64'(cmd_ready), 64'd1);

      // Latency: ADD 5+3
      send(4'd2, 32'd5, 32'd3);
      step();
      chk("lat_t1_valid", 64'(rsp_valid), 64'd0);
      step();
      chk("lat_t2_valid", 64'(rsp_valid), 64'd1);
      chk("add_5_3_data", 64'(rsp_data), 64'd8);
      chk("add_5_3_flags", 64'(rsp_flags), 64'd0);
      take_rsp();

      // Overflow and zero flags
      send(4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
      wait_rsp();
      chk("add_ovf_data", 64'(rsp_data), 64'h8000_0000);
      chk("add_ovf_flags", 64'(rsp_flags), 64'b1001);
      take_rsp();
      send(4'd3, 32'd5, 32'd5);
      wait_rsp();
      chk("sub_zero_data", 64'(rsp_data), 64'd0);
      chk("sub_zero_nz", 64'(rsp_flags[3:2]), 64'b01);
      take_rsp();

      // Back-pressure: 5 accepted, 6th refused until drained
      for (int i = 0; i < 5; i++)
         send(4'(i), 32'(i * 7 + 3), 32'(i + 1));
      cmd_valid = 1'b1;
      cmd_op = 4'd7;
      cmd_a = 32'hA5A5_0F0F;
      cmd_b = 32'h0FF0_1234;
      acc6 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         acc6 = acc6 | last_cf;
      end
      chk("full_no_accept", 64'(acc6), 64'd0);
      chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("full_queued", 64'(exp_q.size()), 64'd5);
      r0 = n_rsp;
      rsp_ready = 1'b1;
      k = 0;
      while (!(acc6 && exp_q.size() == 0) && k < 40) begin
         step();
         if (last_cf) begin
            acc6 = 1'b1;
            cmd_valid = 1'b0;
         end
         k++;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("drain_6th_acc", 64'(acc6), 64'd1);
      chk("drain_rsp_cnt", 64'(n_rsp - r0), 64'd6);

      // Illegal opcode after AND
      a_and = 32'hF0F0_3C3C;
      send(4'd0, a_and, 32'h0FF0_FFFF);
      wait_rsp();
      take_rsp();
      send(4'hF, 32'h1234_5678, 32'h9ABC_DEF0);
      wait_rsp();
      chk("ill_flag", 64'(rsp_illegal), 64'd1);
      chk("ill_data", 64'(rsp_data), 64'd0);
      chk("ill_flags", 64'(rsp_flags), 64'd0);
      chk("ill_alu_ctr", 64'(alu_ctr), 64'd0);
      chk("ill_alu_i1", 64'(alu_i1), 64'(a_and));
      take_rsp();

      // Reset during DRIVE with 3 queued
      for (int i = 0; i < 5; i++)
         send(4'd2, 32'(100 + i), 32'(i));
      wait_rsp();
      take_rsp();
      chk("mid_inflight", 64'(exp_q.size()), 64'd4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("arst_rsp", {27'd0, rsp_valid, rsp_illegal, rsp_flags, rsp_data}, 64'd0);
      chk("arst_alu", {alu_ctr, alu_i1}, 64'd0);
      chk("arst_alu_i2", 64'(alu_i2), 64'd0);
      n_acc = n_acc - exp_q.size();
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("arst_hold_ready", 64'(cmd_ready), 64'd0);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_rel_ready", 64'(cmd_ready), 64'd1);
      r0 = n_rsp;
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) step();
      rsp_ready = 1'b0;
      chk("arst_no_rsp", 64'(n_rsp - r0), 64'd0);
      send(4'd2, 32'd1, 32'd1);
      wait_rsp();
      chk("arst_add_1_1", 64'(rsp_data), 64'd2);
      take_rsp();

      // Random legal traffic with random back-pressure
      for (int c = 0; c < 400; c++) begin
         if (!cmd_valid || last_cf) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_op = 4'($urandom_range(0, 9));
            cmd_a = $urandom;
            cmd_b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
         end
         rsp_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      k = 0;
      while ((exp_q.size() != 0 || rsp_valid) && k < 60) begin
         step();
         k++;
      end
      rsp_ready = 1'b0;
      chk("rand_drained", 64'(exp_q.size()), 64'd0);
      chk("rand_total", 64'(n_rsp), 64'(n_acc));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
